ahb_burst_slave: RTL and testbench
==================================

AHB_BURST_SLAVE -- requirements
Module: ahb_burst_slave

Interface
REQ-001 Parameter DW, default 32: data width in bits; legal values 32 and 64.
REQ-002 Parameter AW, default 10: haddr width in bits.
REQ-003 Parameter MEM_DEPTH, default 128: number of DW-bit words in the internal array mem.
REQ-004 Parameter WAIT_STATES, default 0: wait cycles inserted in every OKAY data phase; range 0..15.
REQ-005 Port hclk, input, 1: sole clock; all state changes on the rising edge.
REQ-006 Port hresetn, input, 1: asynchronous active-low reset.
REQ-007 Port htrans, input, 2: 0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
REQ-008 Port hwrite, input, 1: 1=write, 0=read.
REQ-009 Port haddr, input, AW: byte address.
REQ-010 Port hsize, input, 3: transfer size; bytes per transfer = 2**hsize.
REQ-011 Port hwdata, input, DW: write data, valid in the data phase.
REQ-012 Port slv_busy, input, 1: external stall request.
REQ-013 Port hready, output, 1: transfer-done / slave-ready indication.
REQ-014 Port hresp, output, 1: 0=OKAY, 1=ERROR.
REQ-015 Port hrdata, output, DW: read data.

Function
REQ-016 An address phase is accepted on a rising edge where hready=1 and htrans is NONSEQ or SEQ; htrans IDLE or BUSY gets a zero-wait OKAY with no memory access.
REQ-017 Word index = haddr >> log2(DW/8); byte lane = haddr[log2(DW/8)-1:0].
REQ-018 A transfer is an error when the word index >= MEM_DEPTH, when 2**hsize > DW/8, or when haddr is not aligned to 2**hsize.
REQ-019 The FSM has five states:
- S_IDLE: no data phase.
- S_WAIT: counting wait states.
- S_DATA: final data-phase cycle.
- S_ERR1: first error cycle.
- S_ERR2: second error cycle.
REQ-020 On accepting a valid transfer:
- WAIT_STATES>0: go to S_WAIT with the counter loaded to WAIT_STATES-1.
- WAIT_STATES=0: go directly to S_DATA.
REQ-021 S_WAIT decrements the counter each cycle and moves to S_DATA after the cycle in which the counter is 0; an n-wait transfer therefore shows hready=0 for exactly n data-phase cycles.
REQ-022 On accepting an erroring transfer, go to S_ERR1, then S_ERR2:
- S_ERR1: hready=0, hresp=1.
- S_ERR2: hready=1, hresp=1.
- Memory is not modified.
REQ-023 In S_DATA and S_ERR2, a new address phase may be accepted on the same edge (pipelined); otherwise go to S_IDLE.
REQ-024 hready output by state:
- S_IDLE, S_DATA, S_ERR2: 1.
- S_WAIT, S_ERR1: 0.
- Whenever slv_busy=1: forced to 0.
REQ-025 While slv_busy=1, the FSM and the wait counter hold their values and no transfer is accepted or completed; hresp holds its value.
REQ-026 A write commits on the rising edge that ends S_DATA with hready=1:
- Only the 2**hsize bytes at the lane offset are updated.
- The other bytes of the word are unchanged.
REQ-027 A write data-phase cycle with hready=0 does not modify memory.
REQ-028 hrdata, for a read in S_DATA with hready=1, equals mem[word index] combinationally; it is 0 in every other cycle, including wait and error cycles.
REQ-029 A write followed back-to-back by a read to the same word returns the newly written data.
REQ-030 Address-phase signals (haddr, hwrite, hsize) are registered at acceptance and used for the whole data phase; their later changes are ignored.

Reset
REQ-031 hresetn=0 immediately (asynchronously) forces the following, whatever the state, including mid-transfer:
- FSM to S_IDLE and wait counter to 0.
- hresp=0, hrdata=0, and hready=1 unless slv_busy=1.
REQ-032 Reset discards any pending write; mem contents are not reset.
REQ-033 After hresetn is released, the first rising edge may accept an address phase.

Verification
REQ-034 Defaults; NONSEQ write haddr=0x0C, hsize=2, hwdata=0x5A5A5A5A -> hready=1 in the data phase; mem[3]=0x5A5A5A5A after that edge.
REQ-035 Defaults; back-to-back NONSEQ write 0x10<=0xFFFFFF00 then read 0x10 -> read data phase hrdata=0xFFFFFF00, total 3 cycles.
REQ-036 WAIT_STATES=2; read from 0x20 with mem[8]=0xDFE:
- hready=0 and hrdata=0 for 2 cycles.
- Then hready=1 and hrdata=0xDFE.
REQ-037 Defaults; write haddr=0x200 (index 128) -> hresp=1/hready=0, then hresp=1/hready=1; mem unchanged.
REQ-038 Defaults; byte write haddr=0x05, hsize=0, hwdata=0x0000AB00 with mem[1]=0x11223344 -> mem[1]=0x1122AB44.
REQ-039 WAIT_STATES=3; assert hresetn=0 in the second wait cycle of a write -> hready=1 and hresp=0 immediately; target word unchanged.

Source files
------------

// File: rtl/ahb_burst_slave.sv
// AHB-style memory slave: pipelined address/data phases, programmable wait states,
// two-cycle ERROR response and byte-lane writes into an internal word array.
module ahb_burst_slave #(
   parameter int DW          = 32,
   parameter int AW          = 10,
   parameter int MEM_DEPTH   = 128,
   parameter int WAIT_STATES = 0
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [AW-1:0] haddr,
   input  logic [2:0]    hsize,
   input  logic [DW-1:0] hwdata,
   input  logic          slv_busy,
   output logic          hready,
   output logic          hresp,
   output logic [DW-1:0] hrdata
);

   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [2:0]  LB3     = 3'(LB);
   localparam logic [31:0] DEPTH32 = 32'(MEM_DEPTH);
   localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] widx_q, widx_d;
   logic [LB-1:0] lane_q, lane_d;
   logic [2:0]    size_q, size_d;
   logic          write_q, write_d;

   logic [DW-1:0] mem [MEM_DEPTH];

   // Address-phase decode
   logic [31:0]   word_idx;
   logic [LB-1:0] lane;
   logic [LB-1:0] align_mask;
   logic          addr_err;
   logic          size_err;
   logic          align_err;
   logic          xfer_err;
   logic          ready_state;
   logic          accept;

   assign word_idx = 32'(haddr >> LB);
   assign lane     = haddr[LB-1:0];

   for (genvar gi = 0; gi < LB; gi++) begin : g_align
      assign align_mask[gi] = (3'(gi) < hsize);
   end

   assign addr_err  = (word_idx >= DEPTH32);
   assign size_err  = (hsize > LB3);
   assign align_err = |(lane & align_mask);
   assign xfer_err  = addr_err | size_err | align_err;

   assign ready_state = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign hready      = ready_state & ~slv_busy;
   assign hresp       = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign accept      = hready & htrans[1];

   // slv_busy freezes every piece of control state, including the wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
      if (!slv_busy) begin
         case (state_q)
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_d = S_DATA;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
               state_d = S_IDLE;
               if (accept) begin
                  widx_d  = word_idx[IW-1:0];
                  lane_d  = lane;
                  size_d  = hsize;
                  write_d = hwrite;
                  if (xfer_err) begin
                     state_d = S_ERR1;
                  end else if (WAIT_STATES > 0) begin
                     state_d = S_WAIT;
                     cnt_d   = WS_LOAD;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         widx_q  <= '0;
         lane_q  <= '0;
         size_q  <= 3'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // Byte enables cover [lane, lane + 2**size) of the registered transfer
   logic [4:0]    lane_ext;
   logic [4:0]    lane_end;
   logic [NB-1:0] byte_en;
   logic          commit;

   assign lane_ext = 5'(lane_q);
   assign lane_end = lane_ext + (5'd1 << size_q);

   for (genvar gi = 0; gi < NB; gi++) begin : g_be
      assign byte_en[gi] = (5'(gi) >= lane_ext) && (5'(gi) < lane_end);
   end

   assign commit = (state_q == S_DATA) && write_q && !slv_busy;

   always_ff @(posedge hclk) begin
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b]) begin
               mem[widx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   assign hrdata = ((state_q == S_DATA) && !write_q && !slv_busy) ? mem[widx_q] : '0;

endmodule

// File: tb/tb_ahb_burst_slave.sv
// Scoreboard bench: three slaves (0, 2, 3 wait states) driven with directed and random
// transfers; a per-slave monitor compares each data phase against a byte-level memory model.
module tb_ahb_burst_slave;

   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        hresetn_s [ND];
   logic [1:0]  htrans_s  [ND];
   logic        hwrite_s  [ND];
   logic [9:0]  haddr_s   [ND];
   logic [2:0]  hsize_s   [ND];
   logic [31:0] hwdata_s  [ND];
   logic        busy_s    [ND];
   logic        hready_s  [ND];
   logic        hresp_s   [ND];
   logic [31:0] hrdata_s  [ND];

   ahb_burst_slave #(.WAIT_STATES(0)) u_dut0 (
      .hclk(clk), .hresetn(hresetn_s[0]), .htrans(htrans_s[0]), .hwrite(hwrite_s[0]),
      .haddr(haddr_s[0]), .hsize(hsize_s[0]), .hwdata(hwdata_s[0]), .slv_busy(busy_s[0]),
      .hready(hready_s[0]), .hresp(hresp_s[0]), .hrdata(hrdata_s[0]));

   ahb_burst_slave #(.WAIT_STATES(2)) u_dut2 (
      .hclk(clk), .hresetn(hresetn_s[1]), .htrans(htrans_s[1]), .hwrite(hwrite_s[1]),
      .haddr(haddr_s[1]), .hsize(hsize_s[1]), .hwdata(hwdata_s[1]), .slv_busy(busy_s[1]),
      .hready(hready_s[1]), .hresp(hresp_s[1]), .hrdata(hrdata_s[1]));

   ahb_burst_slave #(.WAIT_STATES(3)) u_dut3 (
      .hclk(clk), .hresetn(hresetn_s[2]), .htrans(htrans_s[2]), .hwrite(hwrite_s[2]),
      .haddr(haddr_s[2]), .hsize(hsize_s[2]), .hwdata(hwdata_s[2]), .slv_busy(busy_s[2]),
      .hready(hready_s[2]), .hresp(hresp_s[2]), .hrdata(hrdata_s[2]));

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] rdata;
      logic [7:0]  ws;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   logic [31:0] mdl [ND][128];
   int          errors = 0;
   int          checks = 0;
   bit          dp_active [ND];
   int          stall_cnt [ND];
   bit          mon_en    [ND];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 2 : 3;
   endfunction

   function automatic int q_size(input int d);
      return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
   endfunction

   function automatic exp_t q_front(input int d);
      return (d == 0) ? q0[0] : (d == 1) ? q1[0] : q2[0];
   endfunction

   task automatic q_push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else if (d == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic q_pop(input int d);
      if (d == 0) void'(q0.pop_front());
      else if (d == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
   endtask

   task automatic q_clear(input int d);
      if (d == 0) q0.delete();
      else if (d == 1) q1.delete();
      else q2.delete();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Transfer rules: in range, no wider than the bus, naturally aligned
   function automatic bit model_err(input logic [9:0] a, input logic [2:0] s);
      int ai     = int'(a);
      int nbytes = 1 << int'(s);
      return (ai / 4 >= 128) || (nbytes > 4) || (ai % nbytes != 0);
   endfunction

   task automatic model_write(input int d, input logic [9:0] a, input logic [2:0] s,
                              input logic [31:0] wd);
      int ai  = int'(a);
      int off = ai % 4;
      int nb  = 1 << int'(s);
      for (int b = off; b < off + nb; b++) begin
         mdl[d][ai / 4][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic mon_step(input int d);
      exp_t cur;
      if (!mon_en[d]) return;
      if (dp_active[d]) begin
         if (q_size(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_sb_underflow: got empty queue, expected a pending entry", d);
            dp_active[d] = 1'b0;
         end else begin
            cur = q_front(d);
            if (hready_s[d]) begin
               chk($sformatf("dut%0d_final_hresp", d), 32'(hresp_s[d]), 32'(cur.err));
               chk($sformatf("dut%0d_final_hrdata", d), hrdata_s[d],
                   (cur.rd && !cur.err) ? cur.rdata : 32'd0);
               chk($sformatf("dut%0d_wait_cycles", d), 32'(stall_cnt[d]), 32'(cur.ws));
               q_pop(d);
               dp_active[d] = 1'b0;
            end else begin
               chk($sformatf("dut%0d_stall_hresp", d), 32'(hresp_s[d]), 32'(cur.err));
               chk($sformatf("dut%0d_stall_hrdata", d), hrdata_s[d], 32'd0);
               if (!busy_s[d]) stall_cnt[d]++;
            end
         end
      end else begin
         chk($sformatf("dut%0d_idle_hready", d), 32'(hready_s[d]), 32'(!busy_s[d]));
         chk($sformatf("dut%0d_idle_hresp", d), 32'(hresp_s[d]), 32'd0);
         chk($sformatf("dut%0d_idle_hrdata", d), hrdata_s[d], 32'd0);
      end
      if (hready_s[d] && htrans_s[d][1]) begin
         dp_active[d] = 1'b1;
         stall_cnt[d] = 0;
      end
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < ND; g++) mon_step(g);
   end

   // Called and returns just after a rising edge; leaves the data phase's hwdata in place
   task automatic drive_xfer(input int d, input bit wr, input logic [9:0] a, input logic [2:0] s,
                             input logic [31:0] wd, input int busy_pct, output int waited);
      exp_t e;
      bit   accepted = 1'b0;
      e.err   = model_err(a, s);
      e.rd    = !wr;
      e.ws    = e.err ? 8'd1 : 8'(ws_of(d));
      e.rdata = (!wr && !e.err) ? mdl[d][int'(a) / 4] : 32'd0;
      htrans_s[d] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
      hwrite_s[d] = wr;
      haddr_s[d]  = a;
      hsize_s[d]  = s;
      waited = 0;
      for (int c = 0; c < 200 && !accepted; c++) begin
         busy_s[d] = ($urandom_range(0, 99) < busy_pct);
         @(negedge clk);
         if (hready_s[d]) accepted = 1'b1;
         else waited++;
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL dut%0d_accept_timeout: got no acceptance in 200 cycles, expected acceptance", d);
         htrans_s[d] = 2'b00;
         return;
      end
      q_push(d, e);
      if (wr && !e.err) model_write(d, a, s, wd);
      hwdata_s[d] = wr ? wd : $urandom();
      htrans_s[d] = 2'b00;
      haddr_s[d]  = 10'($urandom());
      hsize_s[d]  = 3'($urandom());
      hwrite_s[d] = 1'($urandom());
   endtask

   task automatic idle_cycles(input int d, input int n, input int busy_pct);
      for (int i = 0; i < n; i++) begin
         htrans_s[d] = 2'($urandom_range(0, 1));
         haddr_s[d]  = 10'($urandom());
         busy_s[d]   = ($urandom_range(0, 99) < busy_pct);
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      busy_s[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      idle_cycles(d, 8, 0);
      chk($sformatf("dut%0d_drain_queue", d), 32'(q_size(d)), 32'd0);
      chk($sformatf("dut%0d_drain_active", d), 32'(dp_active[d]), 32'd0);
   endtask

   task automatic gen_addr(output logic [9:0] a, output logic [2:0] s);
      int idx, lane, sz, v;
      sz   = int'($urandom_range(0, 2));
      idx  = int'($urandom_range(0, 127));
      lane = (int'($urandom_range(0, 3)) >> sz) << sz;
      if ($urandom_range(0, 9) == 0) begin
         v = int'($urandom_range(0, 2));
         if (v == 0) idx = int'($urandom_range(128, 255));
         else if (v == 1) sz = 3;
         else begin
            sz   = int'($urandom_range(1, 2));
            lane = (sz == 1) ? 1 + 2 * int'($urandom_range(0, 1)) : int'($urandom_range(1, 3));
         end
      end
      a = 10'(idx * 4 + lane);
      s = 3'(sz);
   endtask

   initial begin
      int          w;
      logic [9:0]  ra;
      logic [2:0]  rs;
      logic [31:0] old;
      for (int d = 0; d < ND; d++) begin
         hresetn_s[d] = 1'b1;
         htrans_s[d]  = 2'b00;
         hwrite_s[d]  = 1'b0;
         haddr_s[d]   = '0;
         hsize_s[d]   = '0;
         hwdata_s[d]  = '0;
         busy_s[d]    = 1'b0;
         mon_en[d]    = 1'b0;
         dp_active[d] = 1'b0;
         stall_cnt[d] = 0;
         for (int i = 0; i < 128; i++) mdl[d][i] = '0;
      end
      #1;
      for (int d = 0; d < ND; d++) hresetn_s[d] = 1'b0;
      #2;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("dut%0d_rst_hready", d), 32'(hready_s[d]), 32'd1);
         chk($sformatf("dut%0d_rst_hresp", d), 32'(hresp_s[d]), 32'd0);
         chk($sformatf("dut%0d_rst_hrdata", d), hrdata_s[d], 32'd0);
         busy_s[d] = 1'b1;
         #1;
         chk($sformatf("dut%0d_rst_busy_hready", d), 32'(hready_s[d]), 32'd0);
         busy_s[d] = 1'b0;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         hresetn_s[d] = 1'b1;
         mon_en[d]    = 1'b1;
      end

      // Zero-wait slave: pipelined write/read, out-of-range, byte lane, misalign, oversize
      drive_xfer(0, 1'b1, 10'h00C, 3'd2, 32'h5A5A_5A5A, 0, w);
      chk("dut0_first_edge_accept", 32'(w), 32'd0);
      drive_xfer(0, 1'b0, 10'h00C, 3'd2, 32'h0, 0, w);
      drive_xfer(0, 1'b1, 10'h010, 3'd2, 32'hFFFF_FF00, 0, w);
      drive_xfer(0, 1'b0, 10'h010, 3'd2, 32'h0, 0, w);
      chk("dut0_b2b_read_accept", 32'(w), 32'd0);
      drive_xfer(0, 1'b1, 10'h200, 3'd2, 32'hDEAD_BEEF, 0, w);
      drive_xfer(0, 1'b0, 10'h200, 3'd2, 32'h0, 0, w);
      drive_xfer(0, 1'b1, 10'h004, 3'd2, 32'h1122_3344, 0, w);
      drive_xfer(0, 1'b1, 10'h005, 3'd0, 32'h0000_AB00, 0, w);
      drive_xfer(0, 1'b0, 10'h004, 3'd2, 32'h0, 0, w);
      drive_xfer(0, 1'b1, 10'h006, 3'd2, 32'hCAFE_F00D, 0, w);
      drive_xfer(0, 1'b1, 10'h008, 3'd3, 32'hCAFE_F00D, 0, w);
      drive_xfer(0, 1'b0, 10'h004, 3'd2, 32'h0, 0, w);
      drain(0);

      // Two-wait slave: read of mem[8] after writing 0xDFE
      drive_xfer(1, 1'b1, 10'h020, 3'd2, 32'h0000_0DFE, 0, w);
      drive_xfer(1, 1'b0, 10'h020, 3'd2, 32'h0, 0, w);
      drain(1);

      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 128; i++) drive_xfer(d, 1'b1, 10'(i * 4), 3'd2, $urandom(), 0, w);
         drain(d);
         for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 15) idle_cycles(d, int'($urandom_range(1, 2)), 20);
            gen_addr(ra, rs);
            drive_xfer(d, 1'($urandom_range(0, 1)), ra, rs, $urandom(), 20, w);
         end
         drain(d);
      end

      // Asynchronous reset in the second wait cycle of a three-wait write
      mon_en[2]   = 1'b0;
      old         = mdl[2][16];
      htrans_s[2] = 2'b10;
      hwrite_s[2] = 1'b1;
      haddr_s[2]  = 10'h040;
      hsize_s[2]  = 3'd2;
      busy_s[2]   = 1'b0;
      @(negedge clk);
      chk("dut3_rst_accept_hready", 32'(hready_s[2]), 32'd1);
      @(posedge clk);
      #1;
      htrans_s[2] = 2'b00;
      hwdata_s[2] = ~old;
      @(negedge clk);
      chk("dut3_rst_wait1_hready", 32'(hready_s[2]), 32'd0);
      @(posedge clk);
      #2;
      chk("dut3_rst_wait2_hready", 32'(hready_s[2]), 32'd0);
      hresetn_s[2] = 1'b0;
      #1;
      chk("dut3_async_rst_hready", 32'(hready_s[2]), 32'd1);
      chk("dut3_async_rst_hresp", 32'(hresp_s[2]), 32'd0);
      chk("dut3_async_rst_hrdata", hrdata_s[2], 32'd0);
      @(posedge clk);
      #1;
      hresetn_s[2] = 1'b1;
      dp_active[2] = 1'b0;
      q_clear(2);
      mon_en[2]    = 1'b1;
      drive_xfer(2, 1'b0, 10'h040, 3'd2, 32'h0, 0, w);
      chk("dut3_post_rst_accept", 32'(w), 32'd0);
      drain(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
